// File: rtl/tristate_arb_pkg.sv
// Shared definitions for the tristate bus arbiter: state encoding and default sizing.
package tristate_arb_pkg;

   localparam int unsigned DEF_N         = 4;
   localparam int unsigned DEF_WIDTH     = 4;
   localparam int unsigned DEF_MAX_BURST = 8;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      GRANT      = 2'd1,
      TURNAROUND = 2'd2
   } arb_state_e;

endpackage : tristate_arb_pkg

// File: rtl/rr_pick.sv
// Round-robin winner selection: search starts just after last_owner and wraps modulo N.
module rr_pick #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] last_owner_i,
   output logic [N-1:0]     winner_o,
   output logic [IDX_W-1:0] winner_idx_o,
   output logic             any_o
);

   logic             found;
   logic [IDX_W-1:0] idx;

   // First requester at or after last_owner+1 wins; last_owner itself is checked last
   always_comb begin
      winner_o     = '0;
      winner_idx_o = '0;
      found        = 1'b0;
      idx          = '0;
      for (int unsigned off = 1; off <= N; off++) begin
         idx = IDX_W'((32'(last_owner_i) + off) % N);
         if (!found && req_i[idx]) begin
            found         = 1'b1;
            winner_o[idx] = 1'b1;
            winner_idx_o  = idx;
         end
      end
      any_o = |req_i;
   end

endmodule : rr_pick

// File: rtl/tristate_cell.sv
// Single tristate bus driver: drives data_in onto the shared net while en is high.
module tristate_cell #(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] data_in,
   input  logic             en,
   output wire  [WIDTH-1:0] data_out
);

   // Release the net whenever this driver is not enabled
   assign data_out = en ? data_in : {WIDTH{1'bz}};

endmodule : tristate_cell

// File: rtl/tristate_bus_arbiter.sv
// Round-robin arbiter for a shared tristate bus with burst limit and one-cycle turnaround.
// Optional feature: define TRISTATE_BUS_KEEPER_EN to hold the last driven value when the bus floats.
module tristate_bus_arbiter
   import tristate_arb_pkg::*;
#(
   parameter int unsigned N         = DEF_N,
   parameter int unsigned WIDTH     = DEF_WIDTH,
   parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N-1:0]       req,
   input  logic [N*WIDTH-1:0] data_in,
   output logic [N-1:0]       grant,
   output logic [N-1:0]       en,
   output wire  [WIDTH-1:0]   data_out,
   output logic               busy
);

   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

   arb_state_e       state_q;
   logic [N-1:0]     grant_q;
   logic [CNT_W-1:0] burst_cnt_q;
   logic [IDX_W-1:0] last_owner_q;

   logic [N-1:0]     winner;
   logic [IDX_W-1:0] winner_idx;
   logic             any_req;
   logic             owner_req;

   tri   [WIDTH-1:0] bus_w;

   rr_pick #(
      .N     (N),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req_i        (req),
      .last_owner_i (last_owner_q),
      .winner_o     (winner),
      .winner_idx_o (winner_idx),
      .any_o        (any_req)
   );

   assign owner_req = |(req & grant_q);

   // Arbitration FSM: IDLE and TURNAROUND arbitrate identically, GRANT holds until release or burst limit
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= '0;
         burst_cnt_q  <= '0;
         last_owner_q <= IDX_W'(N - 1);
      end else begin
         case (state_q)
            IDLE, TURNAROUND: begin
               if (any_req) begin
                  state_q      <= GRANT;
                  grant_q      <= winner;
                  last_owner_q <= winner_idx;
                  burst_cnt_q  <= '0;
               end else begin
                  state_q <= IDLE;
                  grant_q <= '0;
               end
            end
            GRANT: begin
               if (owner_req && (burst_cnt_q < CNT_W'(MAX_BURST - 1))) begin
                  burst_cnt_q <= burst_cnt_q + CNT_W'(1);
               end else begin
                  state_q <= TURNAROUND;
                  grant_q <= '0;
               end
            end
            default: begin
               state_q <= IDLE;
               grant_q <= '0;
            end
         endcase
      end
   end

   assign grant = grant_q;
   assign en    = grant_q;
   assign busy  = (state_q != IDLE);

   // One tristate driver per requester onto the shared net
   for (genvar i = 0; i < N; i++) begin : g_drv
      tristate_cell #(
         .WIDTH (WIDTH)
      ) u_cell (
         .data_in  (data_in[i*WIDTH +: WIDTH]),
         .en       (grant_q[i]),
         .data_out (bus_w)
      );
   end

`ifdef TRISTATE_BUS_KEEPER_EN
   logic [WIDTH-1:0] keeper_q;

   // Keeper follows the bus while it is driven and holds it while floating
   always_ff @(posedge clk) begin
      if (rst) begin
         keeper_q <= '0;
      end else if (|grant_q) begin
         keeper_q <= bus_w;
      end
   end

   assign data_out = (|grant_q) ? bus_w : keeper_q;
`else
   assign data_out = bus_w;
`endif

endmodule : tristate_bus_arbiter

// File: tb/tb_tristate_bus_arbiter.sv
// Directed self-checking bench for tristate_bus_arbiter (N=4, WIDTH=4, MAX_BURST=8).
module tb_tristate_bus_arbiter;

   localparam int unsigned N         = 4;
   localparam int unsigned WIDTH     = 4;
   localparam int unsigned MAX_BURST = 8;

   logic               clk;
   logic               rst;
   logic [N-1:0]       req;
   logic [N*WIDTH-1:0] data_in;
   logic [N-1:0]       grant;
   logic [N-1:0]       en;
   wire  [WIDTH-1:0]   data_out;
   logic               busy;

   int unsigned        n_checks;
   int unsigned        n_fail;
   logic [WIDTH-1:0]   kept_exp;

   tristate_bus_arbiter #(
      .N         (N),
      .WIDTH     (WIDTH),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .data_in  (data_in),
      .grant    (grant),
      .en       (en),
      .data_out (data_out),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [WIDTH-1:0] lane_of(input logic [N-1:0] g);
      logic [WIDTH-1:0] v;
      v = '0;
      for (int i = 0; i < int'(N); i++) begin
         if (g[i]) v = data_in[i*WIDTH +: WIDTH];
      end
      return v;
   endfunction

   // Check grant/en/busy and the bus value for the current cycle
   task automatic expect_cycle(input string tag, input logic [N-1:0] g, input logic b);
      check_val({tag, "/grant"}, 32'(grant), 32'(g));
      check_val({tag, "/en"}, 32'(en), 32'(g));
      check_val({tag, "/busy"}, 32'(busy), 32'(b));
      if (g != '0) begin
         check_val({tag, "/data"}, 32'(data_out), 32'(lane_of(g)));
         kept_exp = lane_of(g);
      end else begin
`ifdef TRISTATE_BUS_KEEPER_EN
         check_val({tag, "/keep"}, 32'(data_out), 32'(kept_exp));
`endif
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      step();
      step();
      rst = 1'b0;
      kept_exp = '0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      kept_exp = '0;
      rst      = 1'b1;
      req      = '0;
      data_in  = 16'h9A75;  // lane3=9 lane2=A lane1=7 lane0=5

      // Reset, no requests
      do_reset();
      expect_cycle("rst_idle", 4'b0000, 1'b0);
      step();
      expect_cycle("rst_idle2", 4'b0000, 1'b0);

      // Single requester 0 for three cycles, then release
      req = 4'b0001;
      step();
      expect_cycle("r0_c0", 4'b0001, 1'b1);
      step();
      expect_cycle("r0_c1", 4'b0001, 1'b1);
      step();
      expect_cycle("r0_c2", 4'b0001, 1'b1);
      req = 4'b0000;
      step();
      expect_cycle("r0_ta", 4'b0000, 1'b1);
      step();
      expect_cycle("r0_idle", 4'b0000, 1'b0);

      // All requesting: burst-limited round robin from requester 0
      do_reset();
      req = 4'b1111;
      step();
      for (int k = 0; k < 5; k++) begin
         for (int b = 0; b < int'(MAX_BURST); b++) begin
            expect_cycle($sformatf("rr_k%0d_b%0d", k, b), 4'(1 << (k % 4)), 1'b1);
            if (k == 4 && b == int'(MAX_BURST) - 1) req = 4'b0000;
            step();
         end
         expect_cycle($sformatf("rr_ta%0d", k), 4'b0000, 1'b1);
         step();
      end
      expect_cycle("rr_idle", 4'b0000, 1'b0);

      // Requester 0 drops after two cycles, requester 1 follows after turnaround
      do_reset();
      req = 4'b0011;
      step();
      expect_cycle("drop_g0a", 4'b0001, 1'b1);
      step();
      expect_cycle("drop_g0b", 4'b0001, 1'b1);
      req = 4'b0010;
      step();
      expect_cycle("drop_ta", 4'b0000, 1'b1);
      step();
      expect_cycle("drop_g1", 4'b0010, 1'b1);
      req = 4'b0000;
      step();
      expect_cycle("drop_ta2", 4'b0000, 1'b1);
      step();
      expect_cycle("drop_idle", 4'b0000, 1'b0);

      // Reset mid-burst of requester 2, priority restarts at requester 0
      req = 4'b0100;
      step();
      expect_cycle("mid_g2", 4'b0100, 1'b1);
      step();
      expect_cycle("mid_g2b", 4'b0100, 1'b1);
      rst = 1'b1;
      kept_exp = '0;
      step();
      expect_cycle("mid_rst", 4'b0000, 1'b0);
      rst = 1'b0;
      req = 4'b0111;
      step();
      expect_cycle("post_g0", 4'b0001, 1'b1);
      req = 4'b0110;
      step();
      expect_cycle("post_ta0", 4'b0000, 1'b1);
      step();
      expect_cycle("post_g1", 4'b0010, 1'b1);
      req = 4'b0100;
      step();
      expect_cycle("post_ta1", 4'b0000, 1'b1);
      step();
      expect_cycle("post_g2", 4'b0100, 1'b1);
      req = 4'b0000;
      step();
      expect_cycle("post_ta2", 4'b0000, 1'b1);
      step();
      expect_cycle("post_idle", 4'b0000, 1'b0);

      // Lone continuous requester 3: full burst, turnaround, regrant
      req = 4'b1000;
      step();
      for (int b = 0; b < int'(MAX_BURST); b++) begin
         expect_cycle($sformatf("solo_b%0d", b), 4'b1000, 1'b1);
         step();
      end
      expect_cycle("solo_ta", 4'b0000, 1'b1);
      step();
      expect_cycle("solo_regrant", 4'b1000, 1'b1);
      req = 4'b0000;
      step();
      expect_cycle("solo_ta2", 4'b0000, 1'b1);
      step();
      expect_cycle("solo_idle", 4'b0000, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_tristate_bus_arbiter

// File: doc/tristate_bus_arbiter.md
TRISTATE_BUS_ARBITER -- requirements
Module: tristate_bus_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters sharing the bus.
REQ-002 Parameter WIDTH, default 4: bus data width.
REQ-003 Parameter MAX_BURST, default 8: maximum consecutive cycles one owner holds the bus.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req  input  N  per-requester bus request, level-sensitive.
REQ-007 data_in  input  N*WIDTH  requester i's data on bits [i*WIDTH +: WIDTH].
REQ-008 grant  output  N  one-hot current owner, registered.
REQ-009 en  output  N  per-driver tristate enable, registered, equal to grant.
REQ-010 data_out  output  WIDTH  shared bus value.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 States SHALL be IDLE, GRANT, TURNAROUND; 2-bit encoding.
REQ-013 IDLE: grant=0. Any req high at an edge -> GRANT, grant set one-hot to the winner at that edge (1-cycle latency req->grant).
REQ-014 Arbitration SHALL be round-robin: search starts at last_owner+1 and wraps modulo N; the winner becomes last_owner.
REQ-015 GRANT: owner keeps the bus while req[owner]=1 and burst_cnt < MAX_BURST-1; burst_cnt increments each granted cycle.
REQ-016 GRANT exit: req[owner]=0, or burst_cnt = MAX_BURST-1 with req still high -> TURNAROUND; grant=0 from that edge.
REQ-017 TURNAROUND SHALL last exactly one cycle with all en=0; it then arbitrates exactly as IDLE (-> GRANT if any req, else IDLE).
REQ-018 A burst-limited owner still requesting SHALL re-enter arbitration as the lowest-priority requester (pointer already advanced past it).
REQ-019 At most one en bit SHALL be high in any cycle; en SHALL never switch directly from one owner to another without an all-zero cycle.
REQ-020 burst_cnt SHALL clear to 0 on every entry to GRANT; width is clog2(MAX_BURST).
REQ-021 Bus SHALL be an internal wire driven by N tristate cells; data_out = data_in of owner when any en high.
REQ-022 Requests arriving during TURNAROUND SHALL be considered at the TURNAROUND exit edge; none are lost while held high.
REQ-023 Single requester continuously requesting: GRANT for MAX_BURST cycles, TURNAROUND 1 cycle, GRANT again (same owner).

Reset
REQ-024 On rst high at an edge: state=IDLE, grant=0, en=0, busy=0, burst_cnt=0, last_owner=N-1 (requester 0 highest priority first).
REQ-025 Reset mid-burst SHALL drop en at that same edge; no TURNAROUND cycle is required after reset.
REQ-026 rst SHALL take precedence over all requests.

Configuration
REQ-027 Macro TRISTATE_BUS_KEEPER_EN: when defined, a WIDTH-bit keeper register captures the bus each cycle any en is high, and data_out = keeper value when all en=0 (keeper resets to 0).
REQ-028 Without TRISTATE_BUS_KEEPER_EN, data_out SHALL be high-impedance (all z) whenever all en=0.

Structure
REQ-029 Shared package tristate_arb_pkg SHALL hold state encodings (IDLE=0, GRANT=1, TURNAROUND=2) and default N/WIDTH/MAX_BURST constants.
REQ-030 The N bus drivers SHALL be instances of the existing tristate cell (data_in, en, data_out); round-robin pick logic SHALL be a sub-module rr_pick (req, last_owner -> one-hot winner).

Verification
REQ-031 Reset, no req: grant=0, en=0, busy=0, data_out=z (macro off) / 0 (macro on).
REQ-032 req=0001, data_in[3:0]=5, held 3 cycles then dropped: grant=0001 one cycle after req, data_out=5 for 3 cycles, then 1 TURNAROUND cycle, IDLE.
REQ-033 req=1111 held constantly, MAX_BURST=8: grant sequence 0001,0010,0100,1000,0001, each 8 cycles, separated by single all-zero cycles.
REQ-034 req=0011, requester 0 drops after 2 cycles: grant 0001 x2, 0000 x1, 0010; en never has two bits set.
REQ-035 rst asserted during grant=0100: en=0000 at that edge, next req=0100 wins again only after requesters 0,1 (priority restarted at 0).
REQ-036 Macro on: owner drives 7 then releases: data_out stays 7 through TURNAROUND and IDLE until next owner drives.
